// File: rtl/tl_pkg.sv
// Shared transaction-layer definitions used by the egress collector and the ingress router.
// Covers word and channel geometry, the destination-tag field and the collector state encoding.
package tl_pkg;

    localparam int DATA_W = 10;
    localparam int CH_W   = 2;
    localparam int NUM_CH = 4;

    // The destination tag occupies the top CH_W bits of every word.
    localparam int TAG_W  = CH_W;
    localparam int TAG_HI = DATA_W - 1;
    localparam int TAG_LO = DATA_W - TAG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef logic [CH_W-1:0] ch_idx_t;

    function automatic ch_idx_t next_idx(input ch_idx_t idx);
        return idx + ch_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: returns the first requesting channel at or after ptr.
// Shared between the egress collector and the ingress side.
module rr_select
    import tl_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant,
    output logic              any_req
);

    logic [CH_W-1:0] idx;

    // Walk offsets from farthest to nearest so the closest requester to ptr wins.
    always_comb begin
        grant = ptr;
        idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = ptr + CH_W'(i);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/egress_collector.sv
// Read end of the four destination FIFOs (channels 4..7): round-robin pops one word at a time
// and presents it on a registered valid/ready egress port, flagging words whose tag mismatches.
module egress_collector
    import tl_pkg::*;
#(
    parameter int DATA_W = tl_pkg::DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in4,
    input  logic [DATA_W-1:0] data_in5,
    input  logic [DATA_W-1:0] data_in6,
    input  logic [DATA_W-1:0] data_in7,
    input  logic              empty4,
    input  logic              empty5,
    input  logic              empty6,
    input  logic              empty7,
    output logic              rd4,
    output logic              rd5,
    output logic              rd6,
    output logic              rd7,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              err_dest,
    output logic [CNT_W-1:0]  word_cnt
);

    state_t              state;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   rd_q;
    logic [NUM_CH-1:0]   rd_nxt;
    logic [CH_W-1:0]     ptr_q;
    logic [CH_W-1:0]     ptr_nxt;
    logic [CH_W-1:0]     sel_q;
    logic [CH_W-1:0]     sel_nxt;
    logic [CH_W-1:0]     grant;
    logic                any_req;
    logic                accept;
    logic                take_grant;
    logic [DATA_W-1:0]   data_arr [NUM_CH];
    logic [DATA_W-1:0]   sel_data;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_nxt;
    logic                valid_q;
    logic                valid_nxt;
    logic                err_q;
    logic                err_nxt;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_nxt;

    assign data_arr[0] = data_in4;
    assign data_arr[1] = data_in5;
    assign data_arr[2] = data_in6;
    assign data_arr[3] = data_in7;
    assign sel_data    = data_arr[sel_q];

    assign req = ~{empty7, empty6, empty5, empty4};

    rr_select u_rr_select (
        .req     (req),
        .ptr     (ptr_q),
        .grant   (grant),
        .any_req (any_req)
    );

    // Empty flags only matter when idle or on the cycle the held word is accepted.
    assign accept     = (state == HOLD) && ready_in;
    assign take_grant = ((state == IDLE) || accept) && any_req;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = WAIT;
            WAIT: state_nxt = CAPT;
            CAPT: state_nxt = HOLD;
            HOLD: if (ready_in) state_nxt = any_req ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_nxt    = '0;
        ptr_nxt   = ptr_q;
        sel_nxt   = sel_q;
        data_nxt  = data_q;
        valid_nxt = valid_q;
        err_nxt   = err_q;
        cnt_nxt   = cnt_q;

        if (take_grant) begin
            rd_nxt[grant] = 1'b1;
            ptr_nxt       = next_idx(grant);
            sel_nxt       = grant;
        end

        // A mis-tagged word is still forwarded; only the sticky flag records it.
        if (state == CAPT) begin
            data_nxt  = sel_data;
            valid_nxt = 1'b1;
            if (sel_data[DATA_W-1 -: TAG_W] != sel_q) begin
                err_nxt = 1'b1;
            end
        end

        if (accept) begin
            valid_nxt = 1'b0;
            cnt_nxt   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd_q    <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rd_q    <= rd_nxt;
            ptr_q   <= ptr_nxt;
            sel_q   <= sel_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign rd4       = rd_q[0];
    assign rd5       = rd_q[1];
    assign rd6       = rd_q[2];
    assign rd7       = rd_q[3];
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign err_dest  = err_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_egress_collector.sv
// Directed bench for egress_collector: models the four destination FIFOs and the link consumer,
// and checks outputs against hand-computed values.
module tb_egress_collector;

    localparam int DATA_W = 10;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset_L = 1'b0;
    logic [DATA_W-1:0] din [4];
    logic [3:0]        emp = 4'hF;
    logic              rd4, rd5, rd6, rd7;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              ready_in = 1'b0;
    logic              err_dest;
    logic [CNT_W-1:0]  word_cnt;

    logic [DATA_W-1:0] fq [4][$];
    logic [DATA_W-1:0] acc_q [$];
    int                acc_t [$];
    int                grant_log [$];
    int                acc_cnt = 0;
    int                rd_cnt [4];
    int                multi_rd = 0;
    int                long_rd = 0;
    int                underflow = 0;
    int                cyc = 0;
    logic [3:0]        rdv;
    logic [3:0]        prev_rd = 4'h0;
    int                checks = 0;
    int                passed = 0;

    egress_collector #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in4  (din[0]),
        .data_in5  (din[1]),
        .data_in6  (din[2]),
        .data_in7  (din[3]),
        .empty4    (emp[0]),
        .empty5    (emp[1]),
        .empty6    (emp[2]),
        .empty7    (emp[3]),
        .rd4       (rd4),
        .rd5       (rd5),
        .rd6       (rd6),
        .rd7       (rd7),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .err_dest  (err_dest),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // FIFO model and observers: pop on a visible rd pulse, log grants and accepted words.
    always @(negedge clk) begin
        rdv = {rd7, rd6, rd5, rd4};
        if ($countones(rdv) > 1) multi_rd++;
        if ((rdv & prev_rd) != 4'h0) long_rd++;
        prev_rd = rdv;
        for (int i = 0; i < 4; i++) begin
            if (rdv[i]) begin
                rd_cnt[i]++;
                grant_log.push_back(i);
                if (fq[i].size() > 0) din[i] = fq[i].pop_front();
                else underflow++;
                emp[i] = (fq[i].size() == 0);
            end
        end
        if (valid_out && ready_in) begin
            acc_q.push_back(data_out);
            acc_t.push_back(cyc);
            acc_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [DATA_W-1:0] word);
        fq[ch].push_back(word);
        emp[ch] = 1'b0;
    endtask

    task automatic clearLogs();
        acc_q.delete();
        acc_t.delete();
        grant_log.delete();
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) rd_cnt[i] = 0;
    endtask

    task automatic holdReset();
        step();
        reset_L  = 1'b0;
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) fq[i].delete();
        emp = 4'hF;
        clearLogs();
        repeat (2) step();
    endtask

    task automatic releaseReset();
        reset_L = 1'b1;
        step();
    endtask

    task automatic waitAcc(input int target, input int bound, input string tag);
        int n;
        n = 0;
        while (acc_cnt < target && n < bound) begin
            sample();
            n++;
        end
        checkOutput(tag, 32'(acc_cnt >= target), 32'd1);
    endtask

    task automatic waitValid(input int bound, input string tag);
        int n;
        n = 0;
        while (valid_out !== 1'b1 && n < bound) begin
            sample();
            n++;
        end
        checkOutput(tag, 32'(valid_out), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            din[i]    = '0;
            rd_cnt[i] = 0;
        end

        // Reset state
        holdReset();
        checkOutput("rst_rd", 32'({rd7, rd6, rd5, rd4}), 32'h0);
        checkOutput("rst_data", 32'(data_out), 32'h0);
        checkOutput("rst_valid", 32'(valid_out), 32'h0);
        checkOutput("rst_err", 32'(err_dest), 32'h0);
        checkOutput("rst_cnt", 32'(word_cnt), 32'h0);
        releaseReset();

        // Single word on channel 5
        ready_in = 1'b1;
        applyStimulus(1, 10'h155);
        waitAcc(1, 20, "t1_timeout");
        checkOutput("t1_data", 32'(data_out), 32'h155);
        checkOutput("t1_valid", 32'(valid_out), 32'h1);
        sample();
        checkOutput("t1_valid_drop", 32'(valid_out), 32'h0);
        checkOutput("t1_cnt", 32'(word_cnt), 32'd1);
        checkOutput("t1_err", 32'(err_dest), 32'h0);
        checkOutput("t1_rd5_cnt", 32'(rd_cnt[1]), 32'd1);
        checkOutput("t1_rd_other", 32'(rd_cnt[0] + rd_cnt[2] + rd_cnt[3]), 32'd0);

        // Fairness and throughput with all four FIFOs holding three words
        holdReset();
        releaseReset();
        ready_in = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                applyStimulus(c, DATA_W'((c << 8) | (r << 4) | c));
            end
        end
        waitAcc(12, 100, "t2_timeout");
        sample();
        checkOutput("t2_cnt", 32'(word_cnt), 32'd12);
        checkOutput("t2_grants", 32'(grant_log.size()), 32'd12);
        for (int k = 0; k < 12 && k < grant_log.size(); k++) begin
            checkOutput("t2_order", 32'(grant_log[k]), 32'(k % 4));
        end
        for (int k = 0; k < 12 && k < acc_q.size(); k++) begin
            checkOutput("t2_word", 32'(acc_q[k]), 32'(((k % 4) << 8) | ((k / 4) << 4) | (k % 4)));
        end
        for (int k = 1; k < 12 && k < acc_t.size(); k++) begin
            checkOutput("t2_spacing", 32'(acc_t[k] - acc_t[k-1]), 32'd3);
        end

        // Backpressure: ten stalled cycles, then accept with a second word waiting
        holdReset();
        releaseReset();
        applyStimulus(0, 10'h0AB);
        waitValid(20, "t3_valid_timeout");
        applyStimulus(1, 10'h1CD);
        for (int k = 0; k < 10; k++) begin
            sample();
            checkOutput("t3_hold_valid", 32'(valid_out), 32'h1);
            checkOutput("t3_hold_data", 32'(data_out), 32'h0AB);
        end
        checkOutput("t3_no_rd", 32'(rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3]), 32'd1);
        step();
        ready_in = 1'b1;
        sample();
        sample();
        checkOutput("t3_valid_drop", 32'(valid_out), 32'h0);
        checkOutput("t3_cnt", 32'(word_cnt), 32'd1);
        checkOutput("t3_b2b_rd5", 32'(rd5), 32'h1);
        waitAcc(2, 20, "t3_timeout");
        checkOutput("t3_second", 32'(acc_q[acc_q.size()-1]), 32'h1CD);
        sample();
        checkOutput("t3_cnt2", 32'(word_cnt), 32'd2);

        // Tag mismatch on channel 6 is forwarded and sticks
        holdReset();
        releaseReset();
        ready_in = 1'b1;
        applyStimulus(2, 10'h1AA);
        waitAcc(1, 20, "t4_timeout");
        checkOutput("t4_fwd", 32'(acc_q[0]), 32'h1AA);
        checkOutput("t4_err", 32'(err_dest), 32'h1);
        step();
        applyStimulus(0, 10'h011);
        waitAcc(2, 20, "t4_timeout2");
        sample();
        checkOutput("t4_word2", 32'(acc_q[acc_q.size()-1]), 32'h011);
        checkOutput("t4_err_sticky", 32'(err_dest), 32'h1);
        step();
        reset_L = 1'b0;
        #1;
        checkOutput("t4_err_clear", 32'(err_dest), 32'h0);

        // Asynchronous reset while a word is held, then restart at channel 4
        holdReset();
        releaseReset();
        applyStimulus(1, 10'h1CC);
        waitValid(20, "t5_valid_timeout");
        step();
        reset_L = 1'b0;
        #1;
        checkOutput("t5_valid", 32'(valid_out), 32'h0);
        checkOutput("t5_data", 32'(data_out), 32'h0);
        checkOutput("t5_rd", 32'({rd7, rd6, rd5, rd4}), 32'h0);
        holdReset();
        releaseReset();
        ready_in = 1'b1;
        applyStimulus(0, 10'h022);
        applyStimulus(3, 10'h3EE);
        waitAcc(2, 30, "t5_timeout");
        checkOutput("t5_first_grant", 32'(grant_log[0]), 32'd0);
        checkOutput("t5_word0", 32'(acc_q[0]), 32'h022);
        checkOutput("t5_word1", 32'(acc_q[1]), 32'h3EE);

        // Counter wrap after 256 acceptances
        holdReset();
        releaseReset();
        ready_in = 1'b1;
        for (int k = 0; k < 255; k++) applyStimulus(0, DATA_W'(k & 8'hFF));
        waitAcc(255, 900, "t6_timeout");
        sample();
        checkOutput("t6_cnt255", 32'(word_cnt), 32'd255);
        applyStimulus(0, 10'h0FF);
        waitAcc(256, 20, "t6_timeout2");
        sample();
        checkOutput("t6_wrap", 32'(word_cnt), 32'd0);

        // Protocol invariants over the whole run
        checkOutput("one_hot_rd", 32'(multi_rd), 32'd0);
        checkOutput("rd_width", 32'(long_rd), 32'd0);
        checkOutput("no_underflow", 32'(underflow), 32'd0);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/egress_collector.md
Name: egress_collector

Overview:
- Drains the four per-destination FIFOs (channels 4..7) that the transaction-layer routing stage fills.
- Round-robin arbitration merges them into a single 10-bit egress stream with a valid/ready handshake toward the link side.
- Acts as the read end of the destination FIFOs: asserts rd only on non-empty, captures the popped word, and holds it until the consumer accepts it.

Parameters:
- DATA_W, 10, word width; bits [DATA_W-1:DATA_W-2] carry the destination tag.
- CNT_W, 8, width of the accepted-word counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_L  in  1  reset: asynchronous, active-low.
- data_in4..data_in7  in  DATA_W each  FIFO read data; valid the cycle after the matching rd pulse.
- empty4..empty7  in  1 each  FIFO empty flags.
- rd4..rd7  out  1 each  FIFO pop strobes, registered; at most one high per cycle, each high for exactly one cycle.
- data_out  out  DATA_W  egress word, registered.
- valid_out  out  1  egress word valid.
- ready_in  in  1  downstream accepts when valid_out & ready_in.
- err_dest  out  1  sticky flag: a word's tag did not match its source channel.
- word_cnt  out  CNT_W  count of accepted egress words; wraps modulo 2^CNT_W.

Behaviour:
- Reset, asynchronous on reset_L=0:
  - rd4..7=0, data_out=0, valid_out=0, err_dest=0, word_cnt=0.
  - Round-robin pointer ptr=0 (channel 4); state=IDLE.
- Grant selection: first channel with empty=0, searching ptr, ptr+1, ... modulo 4. On a grant, ptr <= granted index + 1 (mod 4) and sel <= granted index.
- States:
  - IDLE:
    - If any empty=0: rd[grant]<=1, go to WAIT.
    - Otherwise stay; all rd stay 0.
  - WAIT:
    - The rd pulse is visible this cycle.
    - rd<=0; go to CAPT.
    - Empty flags are ignored.
  - CAPT:
    - data_out<=data_in[sel], valid_out<=1.
    - If data_in[sel][9:8] != sel, err_dest<=1; the word is still forwarded.
    - Go to HOLD.
  - HOLD, valid_out=1, data_out stable:
    - While ready_in=0: stay; no new rd.
    - On ready_in=1: valid_out<=0 and word_cnt<=word_cnt+1. Then:
      - any empty=0: issue rd[grant]<=1 in the same cycle and go to WAIT (back-to-back);
      - otherwise go to IDLE.
- Latency and throughput:
  - Empty falls in cycle n (IDLE) -> rd high in n+1 -> data sampled in n+2 -> valid_out high from n+3.
  - Sustained throughput: 1 word per 3 cycles with ready_in held high.
- Fairness: with all four channels non-empty, service order is 4,5,6,7,4,...; no channel waits more than 3 grants.
- Empty sampling:
  - Empty is sampled only in IDLE, or in HOLD on the accepting cycle.
  - A channel that goes empty between grant and WAIT is not re-checked; the FIFO is responsible for not popping when empty.
- err_dest stays set until reset.
- word_cnt at 2^CNT_W-1 wraps to 0 on the next acceptance.
- Reset mid-operation: the in-flight word is lost, and the FIFO has already been popped. This is accepted behaviour; the upper layer re-syncs after link reset.
- The value of ready_in while valid_out=0 has no effect.

Decomposition:
- Shared package `tl_pkg`:
  - DATA_W, CH_W=2, NUM_CH=4;
  - state encoding IDLE=0, WAIT=1, CAPT=2, HOLD=3;
  - destination-tag field position constants, shared with the ingress router.
- Sub-module `rr_select`, combinational:
  - inputs: 4-bit request (~empty) and a 2-bit ptr;
  - outputs: grant index and any_req.
  - Reused later by the ingress side.

Test Plan:
- Reset, then only empty5=0 with data_in5=0x155 presented after rd5, ready_in=1:
  - rd5 pulses exactly 1 cycle;
  - data_out=0x155 with valid_out=1 for 1 cycle;
  - word_cnt=1; err_dest=0.
- All four FIFOs hold 3 words each (tags 0..3 matching channels), ready_in=1:
  - grant order 4,5,6,7 repeated 3 times;
  - 12 words at a 3-cycle spacing; word_cnt=12.
- Single word pending, ready_in=0 for 10 cycles then 1:
  - data_out and valid_out stable throughout;
  - no rd pulses during the stall;
  - handshake completes once, word_cnt +1.
- Channel 6 word with tag 1 (0x1AA):
  - forwarded as 0x1AA;
  - err_dest=1 and stays 1 after later correct words;
  - cleared only by reset_L=0.
- reset_L asserted while in HOLD with valid_out=1:
  - outputs 0 immediately (asynchronously);
  - after release, arbitration restarts at channel 4 (ptr=0).
- Preload word_cnt to 255 by sending 255 words, then send 1 more -> word_cnt=0.
